// File: rtl/avalon_sdr_pkg.sv
// Shared types and helpers for the Avalon-MM SDRAM burst master.
// The byteenable helper is sized for buses up to 1024 bits; callers truncate to their own width.
package avalon_sdr_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_CMD,
      RD_DATA,
      WR_BURST,
      DONE
   } state_e;

   localparam int BE_MAX_W = 128;

   function automatic logic [BE_MAX_W-1:0] be_all_ones(input int nbytes);
      logic [BE_MAX_W-1:0] v;
      v = '0;
      for (int i = 0; i < BE_MAX_W; i++) begin
         if (i < nbytes) v[i] = 1'b1;
      end
      return v;
   endfunction

   function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/avalon_burst_calc.sv
// Sizes the next burst from the words still outstanding and advances the byte address past it.
// Address arithmetic wraps silently at 2^ADDR_W.
module avalon_burst_calc
   import avalon_sdr_pkg::*;
#(
   parameter int DATA_W    = 256,
   parameter int ADDR_W    = 32,
   parameter int BURST_W   = 11,
   parameter int MAX_BURST = 16,
   parameter int LEN_W     = 16
) (
   input  logic [LEN_W-1:0]   rem_i,
   input  logic [ADDR_W-1:0]  addr_i,
   output logic [BURST_W-1:0] burst_o,
   output logic [LEN_W-1:0]   rem_o,
   output logic [ADDR_W-1:0]  addr_o
);

   localparam int BYTES = DATA_W / 8;

   assign burst_o = BURST_W'(min_u32(32'(rem_i), 32'(MAX_BURST)));
   assign rem_o   = rem_i - LEN_W'(min_u32(32'(rem_i), 32'(MAX_BURST)));
   assign addr_o  = addr_i + ADDR_W'(burst_o) * ADDR_W'(BYTES);

endmodule

// File: rtl/avalon_sdr_burst.sv
// Avalon-MM burst master: splits a command into bursts of at most MAX_BURST beats,
// streams read beats out and pulls write beats from an input stream, one burst at a time.
module avalon_sdr_burst
   import avalon_sdr_pkg::*;
#(
   parameter int DATA_W    = 256,
   parameter int ADDR_W    = 32,
   parameter int BURST_W   = 11,
   parameter int MAX_BURST = 16,
   parameter int LEN_W     = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_W-1:0]     cmd_addr,
   input  logic [LEN_W-1:0]      cmd_len,
   output logic [DATA_W-1:0]     rd_data,
   output logic                  rd_valid,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   output logic                  busy,
   output logic                  done,
   output logic                  avm_m0_read,
   output logic                  avm_m0_write,
   output logic [ADDR_W-1:0]     avm_m0_address,
   output logic [BURST_W-1:0]    avm_m0_burstcount,
   output logic [DATA_W/8-1:0]   avm_m0_byteenable,
   output logic [DATA_W-1:0]     avm_m0_writedata,
   input  logic [DATA_W-1:0]     avm_m0_readdata,
   input  logic                  avm_m0_readdatavalid,
   input  logic                  avm_m0_waitrequest
);

   localparam int BE_W = DATA_W / 8;
   localparam logic [BE_W-1:0] BE_ALL = BE_W'(be_all_ones(BE_W));

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W-1:0]   naddr_q, naddr_d;
   logic [LEN_W-1:0]    rem_q, rem_d;
   logic [BURST_W-1:0]  burst_q, burst_d;
   logic [BURST_W-1:0]  beat_q, beat_d;
   logic [DATA_W-1:0]   rd_data_q, rd_data_d;
   logic                rd_valid_q, rd_valid_d;

   logic [LEN_W-1:0]    calc_rem_in, calc_rem_out;
   logic [ADDR_W-1:0]   calc_addr_in, calc_addr_out;
   logic [BURST_W-1:0]  calc_burst;
   logic                load, active, wr_xfer, last_beat;

   // In IDLE the calculator sizes the first burst straight from the command.
   assign calc_rem_in  = (state_q == IDLE) ? cmd_len  : rem_q;
   assign calc_addr_in = (state_q == IDLE) ? cmd_addr : naddr_q;

   avalon_burst_calc #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .BURST_W   (BURST_W),
      .MAX_BURST (MAX_BURST),
      .LEN_W     (LEN_W)
   ) u_calc (
      .rem_i   (calc_rem_in),
      .addr_i  (calc_addr_in),
      .burst_o (calc_burst),
      .rem_o   (calc_rem_out),
      .addr_o  (calc_addr_out)
   );

   assign wr_xfer   = (state_q == WR_BURST) && wr_valid && !avm_m0_waitrequest;
   assign last_beat = (beat_q + BURST_W'(1)) == burst_q;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      naddr_d    = naddr_q;
      rem_d      = rem_q;
      burst_d    = burst_q;
      beat_d     = beat_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      load       = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               load   = 1'b1;
               beat_d = '0;
               if (cmd_len == '0)  state_d = DONE;
               else if (cmd_write) state_d = WR_BURST;
               else                state_d = RD_CMD;
            end
         end
         RD_CMD: begin
            if (!avm_m0_waitrequest) begin
               state_d = RD_DATA;
               beat_d  = '0;
            end
         end
         RD_DATA: begin
            if (avm_m0_readdatavalid) begin
               rd_valid_d = 1'b1;
               rd_data_d  = avm_m0_readdata;
               beat_d     = beat_q + BURST_W'(1);
               if (last_beat) begin
                  beat_d = '0;
                  if (rem_q == '0) begin
                     state_d = DONE;
                  end else begin
                     load    = 1'b1;
                     state_d = RD_CMD;
                  end
               end
            end
         end
         WR_BURST: begin
            if (wr_xfer) begin
               beat_d = beat_q + BURST_W'(1);
               if (last_beat) begin
                  beat_d = '0;
                  if (rem_q == '0) state_d = DONE;
                  else             load    = 1'b1;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (load) begin
         addr_d  = calc_addr_in;
         burst_d = calc_burst;
         rem_d   = calc_rem_out;
         naddr_d = calc_addr_out;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   // Burst bookkeeping is always reloaded before use, so it carries no reset.
   always_ff @(posedge clk) begin
      addr_q  <= addr_d;
      naddr_q <= naddr_d;
      rem_q   <= rem_d;
      burst_q <= burst_d;
      beat_q  <= beat_d;
   end

   assign active = (state_q == RD_CMD) || (state_q == RD_DATA) || (state_q == WR_BURST);

   assign cmd_ready         = (state_q == IDLE);
   assign busy              = (state_q != IDLE);
   assign done              = (state_q == DONE);
   assign rd_valid          = rd_valid_q;
   assign rd_data           = rd_data_q;
   assign wr_ready          = wr_xfer;
   assign avm_m0_read       = (state_q == RD_CMD);
   assign avm_m0_write      = (state_q == WR_BURST) && wr_valid;
   assign avm_m0_address    = active ? addr_q  : '0;
   assign avm_m0_burstcount = active ? burst_q : '0;
   assign avm_m0_byteenable = active ? BE_ALL  : '0;
   assign avm_m0_writedata  = (state_q == WR_BURST) ? wr_data : '0;

endmodule

// File: tb/tb_avalon_sdr_burst.sv
// Bench for avalon_sdr_burst: directed commands push expected bursts, beats and completions
// into queues; a slave/monitor process on the falling edge pops and compares.
module tb_avalon_sdr_burst;

   localparam int DATA_W    = 256;
   localparam int ADDR_W    = 32;
   localparam int BURST_W   = 11;
   localparam int MAX_BURST = 16;
   localparam int LEN_W     = 16;
   localparam int BE_W      = DATA_W / 8;

   logic                clk = 1'b0;
   logic                reset;
   logic                cmd_valid, cmd_ready, cmd_write;
   logic [ADDR_W-1:0]   cmd_addr;
   logic [LEN_W-1:0]    cmd_len;
   logic [DATA_W-1:0]   rd_data;
   logic                rd_valid;
   logic [DATA_W-1:0]   wr_data;
   logic                wr_valid, wr_ready, busy, done;
   logic                avm_m0_read, avm_m0_write;
   logic [ADDR_W-1:0]   avm_m0_address;
   logic [BURST_W-1:0]  avm_m0_burstcount;
   logic [BE_W-1:0]     avm_m0_byteenable;
   logic [DATA_W-1:0]   avm_m0_writedata;
   logic [DATA_W-1:0]   avm_m0_readdata;
   logic                avm_m0_readdatavalid, avm_m0_waitrequest;

   always #5 clk = ~clk;

   avalon_sdr_burst #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W), .MAX_BURST(MAX_BURST), .LEN_W(LEN_W)
   ) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .rd_data(rd_data), .rd_valid(rd_valid),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .busy(busy), .done(done),
      .avm_m0_read(avm_m0_read), .avm_m0_write(avm_m0_write),
      .avm_m0_address(avm_m0_address), .avm_m0_burstcount(avm_m0_burstcount),
      .avm_m0_byteenable(avm_m0_byteenable), .avm_m0_writedata(avm_m0_writedata),
      .avm_m0_readdata(avm_m0_readdata), .avm_m0_readdatavalid(avm_m0_readdatavalid),
      .avm_m0_waitrequest(avm_m0_waitrequest)
   );

   typedef struct { logic [31:0] addr; int bc; } burst_t;
   typedef struct { int len; int acc_edge; logic wr; } cmd_t;

   burst_t             exp_burst[$];
   cmd_t               exp_cmd[$];
   logic [DATA_W-1:0]  exp_rd[$];
   logic [DATA_W-1:0]  exp_wr[$];
   logic [DATA_W-1:0]  wr_src[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rd_total = 0;
   bit stall_en = 1'b0;

   initial forever @(posedge clk) cyc++;

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [DATA_W-1:0] pat(input logic [31:0] a);
      return {8{a ^ 32'h5A5A_0000}};
   endfunction

   function automatic logic [DATA_W-1:0] wword(input int i);
      return {8{32'hC0DE_0000 + 32'(i)}};
   endfunction

   // Slave model and monitor
   int          rd_pend_beats, stall_k, wr_beat, cur_bc, rd_cnt, wr_cnt, last_xfer_edge, exp_edge;
   logic [31:0] rd_pend_addr, cur_addr;
   bit          have_k, prev_stall, prev_rdv, after_done, wr_took;
   logic        prev_read, prev_write;
   logic [ADDR_W-1:0]  prev_addr;
   logic [BURST_W-1:0] prev_bc;
   logic [DATA_W-1:0]  prev_wd;
   burst_t      b;
   cmd_t        c;

   initial begin
      avm_m0_readdatavalid = 1'b0;
      avm_m0_readdata      = '0;
      avm_m0_waitrequest   = 1'b0;
      wr_valid = 1'b0;
      wr_data  = '0;
      rd_pend_beats = 0; stall_k = 0; wr_beat = 0; cur_bc = 0; rd_cnt = 0; wr_cnt = 0;
      last_xfer_edge = 0; rd_pend_addr = '0; cur_addr = '0;
      have_k = 0; prev_stall = 0; prev_rdv = 0; after_done = 0; wr_took = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            rd_pend_beats = 0; avm_m0_readdatavalid = 1'b0; avm_m0_waitrequest = 1'b0;
            wr_valid = 1'b0; wr_data = '0; have_k = 0; prev_stall = 0; prev_rdv = 0;
            wr_beat = 0; rd_cnt = 0; wr_cnt = 0; after_done = 0; wr_took = 0;
            exp_burst.delete(); exp_cmd.delete(); exp_rd.delete(); exp_wr.delete(); wr_src.delete();
            continue;
         end
         if (rd_pend_beats > 0 && (!stall_en || $urandom_range(0, 3) != 0)) begin
            avm_m0_readdatavalid = 1'b1;
            avm_m0_readdata      = pat(rd_pend_addr);
            rd_pend_addr   = rd_pend_addr + 32'd32;
            rd_pend_beats--;
            last_xfer_edge = cyc + 1;
         end else begin
            avm_m0_readdatavalid = 1'b0;
         end
         if (!(wr_valid && !wr_took)) begin
            if (wr_src.size() > 0 && (!stall_en || $urandom_range(0, 2) != 0)) begin
               wr_valid = 1'b1;
               wr_data  = wr_src[0];
            end else begin
               wr_valid = 1'b0;
            end
         end
         wr_took = 0;
         #1;
         if (avm_m0_read || avm_m0_write) begin
            if (!have_k) begin
               stall_k = stall_en ? int'($urandom_range(0, 3)) : 0;
               have_k  = 1;
            end
            if (stall_k > 0) begin
               avm_m0_waitrequest = 1'b1;
               stall_k--;
            end else begin
               avm_m0_waitrequest = 1'b0;
               have_k = 0;
            end
         end else begin
            avm_m0_waitrequest = 1'b0;
            have_k = 0;
         end
         #1;
         if (prev_stall) begin
            chk("stall_hold_ctl", {avm_m0_read, avm_m0_write}, {prev_read, prev_write});
            chk("stall_hold_addr", avm_m0_address, prev_addr);
            chk("stall_hold_bc", avm_m0_burstcount, prev_bc);
            chk("stall_hold_wdata", avm_m0_writedata, prev_wd);
         end
         prev_stall = (avm_m0_read || avm_m0_write) && avm_m0_waitrequest;
         prev_read = avm_m0_read; prev_write = avm_m0_write;
         prev_addr = avm_m0_address; prev_bc = avm_m0_burstcount; prev_wd = avm_m0_writedata;
         if (avm_m0_write || wr_ready)
            chk("wr_ready", wr_ready, avm_m0_write && !avm_m0_waitrequest);
         if (avm_m0_read && !avm_m0_waitrequest) begin
            chk("rd_byteenable", avm_m0_byteenable, {BE_W{1'b1}});
            if (exp_burst.size() == 0) begin
               checks++; errors++;
               $display("FAIL rd_burst actual=%0h required=no_burst", avm_m0_address);
            end else begin
               b = exp_burst.pop_front();
               chk("rd_burst_addr", avm_m0_address, b.addr);
               chk("rd_burst_count", avm_m0_burstcount, b.bc);
            end
            rd_pend_addr  = avm_m0_address;
            rd_pend_beats = int'(avm_m0_burstcount);
         end
         if (avm_m0_write && !avm_m0_waitrequest) begin
            chk("wr_byteenable", avm_m0_byteenable, {BE_W{1'b1}});
            if (wr_beat == 0) begin
               if (exp_burst.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL wr_burst actual=%0h required=no_burst", avm_m0_address);
                  cur_addr = avm_m0_address; cur_bc = int'(avm_m0_burstcount);
               end else begin
                  b = exp_burst.pop_front();
                  cur_addr = b.addr; cur_bc = b.bc;
               end
            end
            chk("wr_burst_addr", avm_m0_address, cur_addr);
            chk("wr_burst_count", avm_m0_burstcount, cur_bc);
            wr_beat++;
            if (wr_beat >= cur_bc) wr_beat = 0;
            if (exp_wr.size() == 0) begin
               checks++; errors++;
               $display("FAIL wr_beat actual=%0h required=no_beat", avm_m0_writedata);
            end else begin
               chk("wr_data", avm_m0_writedata, exp_wr.pop_front());
            end
            if (wr_src.size() > 0) void'(wr_src.pop_front());
            wr_took = 1;
            wr_cnt++;
            last_xfer_edge = cyc + 1;
         end
         if (rd_valid || prev_rdv) chk("rd_valid_timing", rd_valid, prev_rdv);
         if (rd_valid) begin
            rd_cnt++;
            rd_total++;
            if (exp_rd.size() == 0) begin
               checks++; errors++;
               $display("FAIL rd_data actual=%0h required=no_beat", rd_data);
            end else begin
               chk("rd_data", rd_data, exp_rd.pop_front());
            end
         end
         prev_rdv = avm_m0_readdatavalid;
         if (after_done) begin
            chk("cmd_ready_after_done", {cmd_ready, busy}, 2'b10);
            after_done = 0;
         end
         if (done) begin
            if (exp_cmd.size() == 0) begin
               checks++; errors++;
               $display("FAIL done actual=1 required=0");
            end else begin
               c = exp_cmd.pop_front();
               exp_edge = (c.len == 0) ? c.acc_edge : last_xfer_edge;
               chk("done_timing", cyc, exp_edge);
               chk("beat_count", c.wr ? wr_cnt : rd_cnt, c.len);
               chk("busy_in_done", {busy, cmd_ready}, 2'b10);
            end
            rd_cnt = 0; wr_cnt = 0; after_done = 1;
         end
      end
   end

   // Stimulus
   task automatic issue(input logic wr, input logic [31:0] addr, input int len);
      int n = 0;
      @(negedge clk); #3;
      while (!cmd_ready && n < 500) begin
         @(negedge clk); #3;
         n++;
      end
      chk("cmd_ready_wait", cmd_ready, 1'b1);
      exp_cmd.push_back('{len: len, acc_edge: cyc + 1, wr: wr});
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = LEN_W'(len);
      @(negedge clk); #3;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((exp_cmd.size() != 0 || !cmd_ready) && n < 3000) begin
         @(negedge clk); #3;
         n++;
      end
      chk({name, "_complete"}, exp_cmd.size(), 0);
      chk({name, "_left"}, exp_rd.size() + exp_wr.size() + exp_burst.size(), 0);
   endtask

   task automatic check_idle_outputs(input string name);
      chk({name, "_rd_wr"}, {avm_m0_read, avm_m0_write}, 2'b00);
      chk({name, "_addr"}, avm_m0_address, 0);
      chk({name, "_bc"}, avm_m0_burstcount, 0);
      chk({name, "_be"}, avm_m0_byteenable, 0);
      chk({name, "_wdata"}, avm_m0_writedata, 0);
      chk({name, "_rd_valid"}, rd_valid, 0);
      chk({name, "_rd_data"}, rd_data, 0);
      chk({name, "_wr_ready"}, wr_ready, 0);
      chk({name, "_busy_done"}, {busy, done}, 2'b00);
      chk({name, "_cmd_ready"}, cmd_ready, 1'b1);
   endtask

   task automatic push_read(input logic [31:0] addr, input int len);
      for (int i = 0; i < len; i++) exp_rd.push_back(pat(addr + 32'(i * 32)));
   endtask

   initial begin
      int base, n;
      reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
      repeat (3) @(negedge clk);
      #3;
      check_idle_outputs("reset");
      reset = 1'b0;

      exp_burst.push_back('{addr: 32'h2000_0000, bc: 1});
      push_read(32'h2000_0000, 1);
      issue(1'b0, 32'h2000_0000, 1);
      wait_idle("rd1");

      exp_burst.push_back('{addr: 32'h2000_0000, bc: 16});
      exp_burst.push_back('{addr: 32'h2000_0200, bc: 16});
      exp_burst.push_back('{addr: 32'h2000_0400, bc: 8});
      push_read(32'h2000_0000, 40);
      issue(1'b0, 32'h2000_0000, 40);
      wait_idle("rd40");

      stall_en = 1'b1;
      exp_burst.push_back('{addr: 32'h3000_0000, bc: 16});
      exp_burst.push_back('{addr: 32'h3000_0200, bc: 4});
      for (int i = 0; i < 20; i++) begin
         wr_src.push_back(wword(i));
         exp_wr.push_back(wword(i));
      end
      issue(1'b1, 32'h3000_0000, 20);
      wait_idle("wr20");
      stall_en = 1'b0;

      issue(1'b0, 32'h2000_1000, 0);
      repeat (3) begin
         chk("zero_len_no_bus", {avm_m0_read, avm_m0_write}, 2'b00);
         @(negedge clk); #3;
      end
      wait_idle("len0_rd");
      issue(1'b1, 32'h3000_1000, 0);
      wait_idle("len0_wr");

      exp_burst.push_back('{addr: 32'hFFFF_FE00, bc: 16});
      exp_burst.push_back('{addr: 32'h0000_0000, bc: 1});
      push_read(32'hFFFF_FE00, 17);
      issue(1'b0, 32'hFFFF_FE00, 17);
      wait_idle("wrap");

      exp_burst.push_back('{addr: 32'h2000_0000, bc: 16});
      push_read(32'h2000_0000, 16);
      issue(1'b0, 32'h2000_0000, 40);
      base = rd_total;
      n = 0;
      while (rd_total < base + 5 && n < 200) begin
         @(negedge clk); #3;
         n++;
      end
      chk("mid_read_progress", rd_total >= base + 5, 1'b1);
      reset = 1'b1;
      @(negedge clk); #3;
      check_idle_outputs("mid_reset");
      reset = 1'b0;

      exp_burst.push_back('{addr: 32'h2000_0040, bc: 1});
      push_read(32'h2000_0040, 1);
      issue(1'b0, 32'h2000_0040, 1);
      wait_idle("rd_after_reset");

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
